usb_tx_ctrl: RTL and testbench

- Transmit-side sequencer for the USB full-speed line.
- Accepts packet bytes over a valid/ready handshake and emits SYNC, then the payload LSB-first.
- Applies bit stuffing and NRZI encoding on the fly, then drives EOP before returning to idle J.
- Sits between the packet-building logic and the D+/D- output drivers. It owns all bit timing.

---
 rtl/usb_tx_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_usb_tx_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: USB full-speed transmit sequencer.
// Takes packet bytes over a valid/ready handshake and sends SYNC, then the payload LSB-first.
// Bit stuffing and NRZI are applied on the fly, and the packet ends with SE0-SE0-J EOP.
// Line bits are launched at bit boundaries: lvl_q always holds the level of the bit now on the wire.
module usb_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dp,
    output logic       dm,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_DATA    = 3'd2,
        S_STUFF   = 3'd3,
        S_EOP_SE0 = 3'd4,
        S_EOP_J   = 3'd5
    } state_t;

    localparam int unsigned    CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;   // bit within SYNC/byte, or SE0 period count
    logic [2:0]    ones_q, ones_d;         // consecutive ones sent, spans byte edges
    logic          lvl_q, lvl_d;           // 1 = J
    logic [7:0]    shift_q, shift_d;
    logic          shift_last_q, shift_last_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          hold_last_q, hold_last_d;
    logic          hold_full_q, hold_full_d;
    logic          last_acc_q, last_acc_d; // final byte of the packet already taken
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          bit_end;
    logic          xfer;
    logic          send_bit;   // launch a new line bit at this boundary
    logic          send_val;   // value of that bit before NRZI
    logic          byte_end;   // SYNC or data byte fully sent, pick the next byte
    logic [2:0]    nxt_idx;

    // Handshake: a byte moves when tx_valid & tx_ready are both high at a rising clk edge.
    // tx_ready depends only on registered state; the producer may hold tx_valid/tx_data/tx_last
    // steady for any number of cycles and nothing changes until the transfer edge.
    assign tx_ready = ~hold_full_q & ~last_acc_q &
                      ((state_q == S_IDLE) | (state_q == S_SYNC) |
                       (state_q == S_DATA) | (state_q == S_STUFF));
    assign xfer     = tx_valid & tx_ready;
    assign bit_end  = (bit_cnt_q == CNT_MAX);
    assign nxt_idx  = bit_idx_q + 3'd1;

    assign dp        = (state_q == S_EOP_SE0) ? 1'b0 : lvl_q;
    assign dm        = (state_q == S_EOP_SE0) ? 1'b0 : ~lvl_q;
    assign tx_busy   = (state_q != S_IDLE);
    assign tx_done   = done_q;
    assign tx_error  = err_q;
    assign dbg_state = state_q;

    // State register and datapath registers, cleared synchronously by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= 3'd0;
            ones_q       <= 3'd0;
            lvl_q        <= 1'b1;
            shift_q      <= 8'h00;
            shift_last_q <= 1'b0;
            hold_data_q  <= 8'h00;
            hold_last_q  <= 1'b0;
            hold_full_q  <= 1'b0;
            last_acc_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            ones_q       <= ones_d;
            lvl_q        <= lvl_d;
            shift_q      <= shift_d;
            shift_last_q <= shift_last_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            hold_full_q  <= hold_full_d;
            last_acc_q   <= last_acc_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic: bit timing, stuffing decisions, byte hand-over and EOP sequencing.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        ones_d       = ones_q;
        lvl_d        = lvl_q;
        shift_d      = shift_q;
        shift_last_d = shift_last_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        hold_full_d  = hold_full_q;
        last_acc_d   = last_acc_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        send_bit     = 1'b0;
        send_val     = 1'b0;
        byte_end     = 1'b0;

        if ((state_q == S_IDLE) || bit_end) bit_cnt_d = '0;
        else                                bit_cnt_d = bit_cnt_q + CW'(1);

        if (xfer) begin
            hold_data_d = tx_data;
            hold_last_d = tx_last;
            hold_full_d = 1'b1;
            if (tx_last) last_acc_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d   = S_SYNC;
                    bit_idx_d = 3'd0;
                    send_bit  = 1'b1;
                    send_val  = SYNC_BYTE[0];
                end
            end
            S_SYNC: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        byte_end = 1'b1;
                    end else begin
                        bit_idx_d = nxt_idx;
                        send_bit  = 1'b1;
                        send_val  = SYNC_BYTE[nxt_idx];
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (ones_q == 3'd6) begin
                        // Stuff bit keeps bit_idx so STUFF knows whether the byte is finished.
                        state_d  = S_STUFF;
                        send_bit = 1'b1;
                        send_val = 1'b0;
                    end else if (bit_idx_q == 3'd7) begin
                        byte_end = 1'b1;
                    end else begin
                        bit_idx_d = nxt_idx;
                        send_bit  = 1'b1;
                        send_val  = shift_q[nxt_idx];
                    end
                end
            end
            S_STUFF: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    if (bit_idx_q == 3'd7) begin
                        byte_end = 1'b1;
                    end else begin
                        bit_idx_d = nxt_idx;
                        send_bit  = 1'b1;
                        send_val  = shift_q[nxt_idx];
                    end
                end
            end
            S_EOP_SE0: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd1) begin
                        state_d = S_EOP_J;
                        lvl_d   = 1'b1;
                    end else begin
                        bit_idx_d = nxt_idx;
                    end
                end
            end
            S_EOP_J: begin
                if (bit_end) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    ones_d     = 3'd0;
                    lvl_d      = 1'b1;
                    last_acc_d = 1'b0;
                    bit_idx_d  = 3'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                lvl_d   = 1'b1;
            end
        endcase

        // After SYNC or a data byte: end the packet, chain the held byte, or flag an underrun.
        if (byte_end) begin
            bit_idx_d = 3'd0;
            if ((state_q != S_SYNC) && shift_last_q) begin
                state_d = S_EOP_SE0;
            end else if (hold_full_q) begin
                shift_d      = hold_data_q;
                shift_last_d = hold_last_q;
                hold_full_d  = 1'b0;
                state_d      = S_DATA;
                send_bit     = 1'b1;
                send_val     = hold_data_q[0];
            end else begin
                err_d   = 1'b1;
                state_d = S_EOP_SE0;
            end
        end

        // NRZI: a 0 toggles the line, a 1 keeps it and extends the run of ones.
        if (send_bit) begin
            lvl_d  = send_val ? lvl_q : ~lvl_q;
            ones_d = send_val ? (ones_q + 3'd1) : 3'd0;
        end
    end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// tb_usb_tx_ctrl: directed bench for usb_tx_ctrl with hand-derived line patterns.
// Line codes: J = 2'b10, K = 2'b01, SE0 = 2'b00 as {dp, dm}.
module tb_usb_tx_ctrl;
    localparam int CPB   = 8;
    localparam int REC_N = 400;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       dp;
    logic       dm;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic [2:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic       rec_dp   [REC_N];
    logic       rec_dm   [REC_N];
    logic       rec_rdy  [REC_N];
    logic       rec_done [REC_N];
    logic       rec_err  [REC_N];
    logic       rec_busy [REC_N];
    logic [8:0] drv_q [$];      // {last, data}
    int         fire_at [$];    // record index of each transfer edge
    logic [1:0] exp_lv [64];
    int         exp_len;
    logic [7:0] mb_bytes [4];

    usb_tx_ctrl #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'h80)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .dp        (dp),
        .dm        (dm),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: presents drv_q entries with tx_valid held high, records outputs each cycle.
    // rec[j] is sampled on the negedge after the posedge that followed decision j.
    task automatic run_packet(input int ncyc);
        logic fire;
        fire_at.delete();
        @(negedge clk);
        if (drv_q.size() > 0) begin
            {tx_last, tx_data} = drv_q.pop_front();
            tx_valid = 1'b1;
        end
        for (int j = 0; j < ncyc; j++) begin
            fire = tx_valid && tx_ready;
            if (fire) fire_at.push_back(j);
            @(negedge clk);
            rec_dp[j]   = dp;
            rec_dm[j]   = dm;
            rec_rdy[j]  = tx_ready;
            rec_done[j] = tx_done;
            rec_err[j]  = tx_error;
            rec_busy[j] = tx_busy;
            if (fire) begin
                if (drv_q.size() > 0) {tx_last, tx_data} = drv_q.pop_front();
                else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'h00;
                    tx_last  = 1'b0;
                end
            end
        end
    endtask

    task automatic load_pattern(input string s);
        exp_len = s.len();
        for (int i = 0; i < exp_len; i++) begin
            if (s[i] == "K")      exp_lv[i] = 2'b01;
            else if (s[i] == "J") exp_lv[i] = 2'b10;
            else                  exp_lv[i] = 2'b00;
        end
    endtask

    // Reference encoder: SYNC + mb_bytes LSB-first, NRZI with stuffing, then SE0 SE0 J.
    task automatic build_expect(input int nb);
        logic       l;
        int         ones;
        logic [7:0] sync_v;
        sync_v  = 8'h80;
        l       = 1'b1;
        ones    = 0;
        exp_len = 0;
        for (int i = 0; i < 8 + 8 * nb; i++) begin
            logic b;
            b = (i < 8) ? sync_v[i] : mb_bytes[(i - 8) / 8][(i - 8) % 8];
            if (!b) begin l = ~l; ones = 0; end
            else ones = ones + 1;
            exp_lv[exp_len] = l ? 2'b10 : 2'b01;
            exp_len = exp_len + 1;
            if (ones == 6) begin
                l = ~l;
                ones = 0;
                exp_lv[exp_len] = l ? 2'b10 : 2'b01;
                exp_len = exp_len + 1;
            end
        end
        exp_lv[exp_len]     = 2'b00;
        exp_lv[exp_len + 1] = 2'b00;
        exp_lv[exp_len + 2] = 2'b10;
        exp_len = exp_len + 3;
    endtask

    function automatic int count_hi(input int sel, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) begin
            if (sel == 0 && rec_rdy[i])  n++;
            if (sel == 1 && rec_done[i]) n++;
            if (sel == 2 && rec_err[i])  n++;
        end
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (dp !== 1'b1)       begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
        n_tests++; if (dm !== 1'b0)       begin n_fail++; $display("FAIL reset_dm: got %b want 0", dm); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        n_tests++; if (tx_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        n_tests++; if (tx_done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done); end
        n_tests++; if (tx_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", tx_error); end
        rst = 1'b0;
    endtask

    task automatic test_single_zero();
        int f;
        drv_q = {9'h100};
        run_packet(175);
        n_tests++;
        if (fire_at.size() == 0 || fire_at[0] > 4) begin
            n_fail++; $display("FAIL zero_start: transfer count %0d, want first at index 0", fire_at.size()); return;
        end
        f = fire_at[0];
        load_pattern("KJKJKJKKJKJKJKJK00J");
        for (int p = 0; p < exp_len; p++) begin
            int bad;
            bad = 0;
            for (int c = 0; c < CPB; c++)
                if ({rec_dp[f+p*CPB+c], rec_dm[f+p*CPB+c]} !== exp_lv[p]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL zero_line bit %0d: got %b (%0d bad cycles) want %b", p, {rec_dp[f+p*CPB], rec_dm[f+p*CPB]}, bad, exp_lv[p]);
            end
        end
        n_tests++; if (rec_done[f+152] !== 1'b1)       begin n_fail++; $display("FAIL zero_done_time: got %b at cycle 152 want 1", rec_done[f+152]); end
        n_tests++; if (count_hi(1, f, f+169) != 1)     begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", count_hi(1, f, f+169)); end
        n_tests++; if (count_hi(0, f, f+151) != 0)     begin n_fail++; $display("FAIL zero_ready_low: got %0d ready cycles want 0", count_hi(0, f, f+151)); end
        n_tests++; if (rec_busy[f] !== 1'b1)           begin n_fail++; $display("FAIL zero_busy_start: got %b want 1", rec_busy[f]); end
        n_tests++; if (rec_busy[f+152] !== 1'b0)       begin n_fail++; $display("FAIL zero_busy_end: got %b want 0", rec_busy[f+152]); end
        n_tests++; if (count_hi(2, f, f+169) != 0)     begin n_fail++; $display("FAIL zero_error: got %0d pulses want 0", count_hi(2, f, f+169)); end
    endtask

    // 8'hFF with a second packet's byte held valid throughout: no effect until IDLE,
    // then accepted in the same cycle as tx_done.
    task automatic test_back_to_back();
        int f;
        drv_q = {9'h1FF, 9'h100};
        run_packet(340);
        n_tests++;
        if (fire_at.size() != 2 || fire_at[0] > 4) begin
            n_fail++; $display("FAIL b2b_transfers: got %0d transfers want 2", fire_at.size()); return;
        end
        f = fire_at[0];
        load_pattern("KJKJKJKKKKKKKJJJJ00J");
        for (int p = 0; p < exp_len; p++) begin
            int bad;
            bad = 0;
            for (int c = 0; c < CPB; c++)
                if ({rec_dp[f+p*CPB+c], rec_dm[f+p*CPB+c]} !== exp_lv[p]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL ff_line bit %0d: got %b (%0d bad cycles) want %b", p, {rec_dp[f+p*CPB], rec_dm[f+p*CPB]}, bad, exp_lv[p]);
            end
        end
        n_tests++; if (rec_done[f+160] !== 1'b1)   begin n_fail++; $display("FAIL ff_done_time: got %b at cycle 160 want 1", rec_done[f+160]); end
        n_tests++; if (count_hi(1, f, f+160) != 1) begin n_fail++; $display("FAIL ff_done_count: got %0d want 1", count_hi(1, f, f+160)); end
        n_tests++; if (fire_at[1] - f != 161)      begin n_fail++; $display("FAIL b2b_accept: got index %0d want 161", fire_at[1] - f); end
        n_tests++; if (rec_done[f+313] !== 1'b1)   begin n_fail++; $display("FAIL b2b_done2: got %b at cycle 313 want 1", rec_done[f+313]); end
        n_tests++; if (rec_dp[f+161] !== 1'b0)     begin n_fail++; $display("FAIL b2b_sync_k: got dp %b want 0", rec_dp[f+161]); end
    endtask

    task automatic test_multi_byte();
        int f;
        drv_q = {9'h0A5, 9'h03C, 9'h181};
        mb_bytes[0] = 8'hA5; mb_bytes[1] = 8'h3C; mb_bytes[2] = 8'h81;
        run_packet(300);
        n_tests++;
        if (fire_at.size() != 3 || fire_at[0] > 4) begin
            n_fail++; $display("FAIL multi_transfers: got %0d want 3", fire_at.size()); return;
        end
        f = fire_at[0];
        build_expect(3);
        for (int p = 0; p < exp_len; p++) begin
            int bad;
            bad = 0;
            for (int c = 0; c < CPB; c++)
                if ({rec_dp[f+p*CPB+c], rec_dm[f+p*CPB+c]} !== exp_lv[p]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL multi_line bit %0d: got %b (%0d bad cycles) want %b", p, {rec_dp[f+p*CPB], rec_dm[f+p*CPB]}, bad, exp_lv[p]);
            end
        end
        n_tests++; if (fire_at[1] - f != 65)       begin n_fail++; $display("FAIL multi_accept2: got %0d want 65", fire_at[1] - f); end
        n_tests++; if (fire_at[2] - f != 129)      begin n_fail++; $display("FAIL multi_accept3: got %0d want 129", fire_at[2] - f); end
        n_tests++; if (count_hi(0, f, f+279) != 2) begin n_fail++; $display("FAIL multi_ready: got %0d ready cycles want 2", count_hi(0, f, f+279)); end
        n_tests++; if (rec_done[f+280] !== 1'b1)   begin n_fail++; $display("FAIL multi_done_time: got %b at cycle 280 want 1", rec_done[f+280]); end
        n_tests++; if (count_hi(2, f, f+290) != 0) begin n_fail++; $display("FAIL multi_error: got %0d pulses want 0", count_hi(2, f, f+290)); end
    endtask

    task automatic test_underrun();
        int f;
        drv_q = {9'h012};
        run_packet(170);
        n_tests++;
        if (fire_at.size() != 1 || fire_at[0] > 4) begin
            n_fail++; $display("FAIL underrun_start: got %0d transfers want 1", fire_at.size()); return;
        end
        f = fire_at[0];
        load_pattern("KJKJKJKKJJKJJKJK00J");
        for (int p = 0; p < exp_len; p++) begin
            int bad;
            bad = 0;
            for (int c = 0; c < CPB; c++)
                if ({rec_dp[f+p*CPB+c], rec_dm[f+p*CPB+c]} !== exp_lv[p]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL underrun_line bit %0d: got %b (%0d bad cycles) want %b", p, {rec_dp[f+p*CPB], rec_dm[f+p*CPB]}, bad, exp_lv[p]);
            end
        end
        n_tests++; if (rec_err[f+128] !== 1'b1)    begin n_fail++; $display("FAIL underrun_err_time: got %b at cycle 128 want 1", rec_err[f+128]); end
        n_tests++; if (count_hi(2, f, f+165) != 1) begin n_fail++; $display("FAIL underrun_err_count: got %0d want 1", count_hi(2, f, f+165)); end
        n_tests++; if (rec_done[f+152] !== 1'b1)   begin n_fail++; $display("FAIL underrun_done: got %b at cycle 152 want 1", rec_done[f+152]); end
    endtask

    task automatic test_reset_mid_packet();
        int f;
        drv_q = {9'h155};
        run_packet(90);
        n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy: got %b want 1", tx_busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (dp !== 1'b1)       begin n_fail++; $display("FAIL rstmid_dp: got %b want 1", dp); end
        n_tests++; if (dm !== 1'b0)       begin n_fail++; $display("FAIL rstmid_dm: got %b want 0", dm); end
        n_tests++; if (tx_busy !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", tx_busy); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", tx_ready); end
        drv_q = {9'h100};
        run_packet(170);
        n_tests++;
        if (fire_at.size() != 1 || fire_at[0] > 4) begin
            n_fail++; $display("FAIL rstmid_restart: got %0d transfers want 1", fire_at.size()); return;
        end
        f = fire_at[0];
        load_pattern("KJKJKJKKJKJKJKJK00J");
        for (int p = 0; p < exp_len; p++) begin
            int bad;
            bad = 0;
            for (int c = 0; c < CPB; c++)
                if ({rec_dp[f+p*CPB+c], rec_dm[f+p*CPB+c]} !== exp_lv[p]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rstmid_line bit %0d: got %b (%0d bad cycles) want %b", p, {rec_dp[f+p*CPB], rec_dm[f+p*CPB]}, bad, exp_lv[p]);
            end
        end
        n_tests++; if (rec_done[f+152] !== 1'b1) begin n_fail++; $display("FAIL rstmid_done: got %b at cycle 152 want 1", rec_done[f+152]); end
    endtask

    // 8'hF0 then 8'hFF: the run of ones crosses the byte edge, and a second stuff follows the last bit.
    task automatic test_cross_byte_stuff();
        int f;
        drv_q = {9'h0F0, 9'h1FF};
        run_packet(245);
        n_tests++;
        if (fire_at.size() != 2 || fire_at[0] > 4) begin
            n_fail++; $display("FAIL cross_transfers: got %0d want 2", fire_at.size()); return;
        end
        f = fire_at[0];
        load_pattern("KJKJKJKKJKJKKKKKKKJJJJJJJK00J");
        for (int p = 0; p < exp_len; p++) begin
            int bad;
            bad = 0;
            for (int c = 0; c < CPB; c++)
                if ({rec_dp[f+p*CPB+c], rec_dm[f+p*CPB+c]} !== exp_lv[p]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL cross_line bit %0d: got %b (%0d bad cycles) want %b", p, {rec_dp[f+p*CPB], rec_dm[f+p*CPB]}, bad, exp_lv[p]);
            end
        end
        n_tests++; if (rec_done[f+232] !== 1'b1)   begin n_fail++; $display("FAIL cross_done_time: got %b at cycle 232 want 1", rec_done[f+232]); end
        n_tests++; if (count_hi(2, f, f+240) != 0) begin n_fail++; $display("FAIL cross_error: got %0d pulses want 0", count_hi(2, f, f+240)); end
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_back_to_back();
        test_multi_byte();
        test_underrun();
        test_reset_mid_packet();
        test_cross_byte_stuff();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
